tank_op_draw_ctl: RTL and testbench

TANK_OP_DRAW_CTL -- requirements
Module: tank_op_draw_ctl

---
 rtl/tank_op_draw_ctl_pkg.sv | 26 ++
 rtl/tank_op_flash_fsm.sv | 68 ++++++
 rtl/tank_op_draw_ctl.sv | 157 +++++++++++++++
 tb/tb_tank_op_draw_ctl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_op_draw_ctl_pkg.sv
// Shared definitions for the tank sprite draw stage: sprite geometry, direction codes,
// flash FSM states and the blink helper.
package tank_op_draw_ctl_pkg;

  localparam int unsigned SpriteSize = 64;
  localparam int unsigned SpriteBits = 6;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirRight = 2'd2,
    DirLeft  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StShow  = 2'd0,
    StFlash = 2'd1,
    StDead  = 2'd2
  } state_t;

  // Blink phase: visible while (frame count / frames-per-toggle) is even.
  function automatic logic blink_on(int unsigned cnt, int unsigned div);
    return ((cnt / div) % 2) == 0;
  endfunction

endpackage

// File: rtl/tank_op_flash_fsm.sv
// Tank visibility FSM: show / hit-flash / dead, with a per-frame flash counter.
// visible only changes on frame_start so a whole frame sees one value.
module tank_op_flash_fsm
  import tank_op_draw_ctl_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 16,
  parameter int unsigned BLINK_DIV    = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   alive,
  input  logic   hit,
  input  logic   frame_start,
  output logic   visible,
  output state_t state
);

  localparam int unsigned CntW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  state_t          state_d;
  logic            vis_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    if (!alive) begin
      state_d = StDead;
    end else if (state == StDead) begin
      state_d = StShow;
    end else if (hit) begin
      state_d = StFlash;
      cnt_d   = '0;
    end else if (state == StFlash && frame_start) begin
      if (cnt_q == CntW'(FLASH_FRAMES - 1)) begin
        state_d = StShow;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Visibility follows the state being entered at this edge.
  always_comb begin
    vis_d = 1'b0;
    unique case (state_d)
      StShow:  vis_d = 1'b1;
      StFlash: vis_d = blink_on(32'(cnt_d), BLINK_DIV);
      StDead:  vis_d = 1'b0;
      default: vis_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StShow;
      cnt_q   <= '0;
      visible <= 1'b1;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
      if (frame_start) begin
        visible <= vis_d;
      end
    end
  end

endmodule

// File: rtl/tank_op_draw_ctl.sv
// Tank sprite overlay: two-stage pipeline that addresses the direction ROMs and muxes the
// sprite pixel over the incoming background, with position/direction latched per frame.
module tank_op_draw_ctl
  import tank_op_draw_ctl_pkg::*;
#(
  parameter logic [11:0] TRANSPARENT  = 12'hF0F,
  parameter int unsigned FLASH_FRAMES = 16,
  parameter int unsigned BLINK_DIV    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [1:0]  dir,
  input  logic        alive,
  input  logic        hit,
  output logic [11:0] address,
  input  logic [11:0] rgb0,
  input  logic [11:0] rgb1,
  input  logic [11:0] rgb2,
  input  logic [11:0] rgb3,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic        vsync_prev, frame_start;
  logic [10:0] xpos_l, ypos_l;
  dir_t        dir_l;
  logic        visible;
  state_t      fsm_state;
  logic        unused_state;

  assign frame_start  = vsync_in & ~vsync_prev;
  assign unused_state = ^fsm_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev <= 1'b0;
      xpos_l     <= '0;
      ypos_l     <= '0;
      dir_l      <= DirUp;
    end else begin
      vsync_prev <= vsync_in;
      if (frame_start) begin
        xpos_l <= xpos;
        ypos_l <= ypos;
        dir_l  <= dir_t'(dir);
      end
    end
  end

  tank_op_flash_fsm #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .BLINK_DIV    (BLINK_DIV)
  ) u_flash_fsm (
    .clk         (clk),
    .rst         (rst),
    .alive       (alive),
    .hit         (hit),
    .frame_start (frame_start),
    .visible     (visible),
    .state       (fsm_state)
  );

  // 12-bit differences: a pixel left of / above the tank wraps large and fails the test.
  logic [11:0] dx, dy;
  logic        in_sprite;
  assign dx        = {1'b0, hcount_in} - {1'b0, xpos_l};
  assign dy        = {1'b0, vcount_in} - {1'b0, ypos_l};
  assign in_sprite = (dx < 12'(SpriteSize)) && (dy < 12'(SpriteSize));

  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [11:0] rgb_s1, rgb_s2;
  logic        in_sprite_s1, vis_s1, draw_s2;
  dir_t        dir_s1, dir_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address      <= '0;
      in_sprite_s1 <= 1'b0;
      vis_s1       <= 1'b0;
      dir_s1       <= DirUp;
      hcount_s1    <= '0;
      vcount_s1    <= '0;
      hsync_s1     <= 1'b0;
      vsync_s1     <= 1'b0;
      hblnk_s1     <= 1'b0;
      vblnk_s1     <= 1'b0;
      rgb_s1       <= '0;
    end else begin
      address      <= {dy[SpriteBits-1:0], dx[SpriteBits-1:0]};
      in_sprite_s1 <= in_sprite;
      vis_s1       <= visible;
      dir_s1       <= dir_l;
      hcount_s1    <= hcount_in;
      vcount_s1    <= vcount_in;
      hsync_s1     <= hsync_in;
      vsync_s1     <= vsync_in;
      hblnk_s1     <= hblnk_in;
      vblnk_s1     <= vblnk_in;
      rgb_s1       <= rgb_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_s2    <= 1'b0;
      dir_s2     <= DirUp;
      rgb_s2     <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else begin
      draw_s2    <= in_sprite_s1 & vis_s1 & ~hblnk_s1 & ~vblnk_s1;
      dir_s2     <= dir_s1;
      rgb_s2     <= rgb_s1;
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
    end
  end

  // ROM data for the stage-1 address arrives in this cycle, so the final mux is combinational
  // over registered controls; with draw_s2 cleared the output is the cleared rgb_s2.
  logic [11:0] rom_sel;
  always_comb begin
    rom_sel = rgb0;
    unique case (dir_s2)
      DirUp:    rom_sel = rgb0;
      DirDown:  rom_sel = rgb1;
      DirRight: rom_sel = rgb2;
      DirLeft:  rom_sel = rgb3;
    endcase
  end

  assign rgb_out = (draw_s2 && rom_sel != TRANSPARENT) ? rom_sel : rgb_s2;

endmodule

// File: tb/tb_tank_op_draw_ctl.sv
// Self-checking bench for tank_op_draw_ctl: per-cycle reference model of the overlay plus
// directed probes of sprite edges, wrap, transparency, direction latch, flash and reset.
module tb_tank_op_draw_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] xpos = '0, ypos = '0;
  logic [1:0]  dir = '0;
  logic        alive = 1'b1, hit = 1'b0;
  logic [11:0] address;
  logic [11:0] rgb0 = '0, rgb1 = '0, rgb2 = '0, rgb3 = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  tank_op_draw_ctl #(
    .TRANSPARENT  (12'hF0F),
    .FLASH_FRAMES (16),
    .BLINK_DIV    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .dir        (dir),
    .alive      (alive),
    .hit        (hit),
    .address    (address),
    .rgb0       (rgb0),
    .rgb1       (rgb1),
    .rgb2       (rgb2),
    .rgb3       (rgb3),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  // Sprite ROM images: mode 0 is a flat colour per direction, mode 1 an address pattern.
  int rom_mode = 0;
  function automatic logic [11:0] rom(int d, logic [11:0] a);
    logic [11:0] flat [4];
    flat = '{12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0};
    if (a == 12'h041) return 12'hF0F;
    if (rom_mode == 0) return flat[d];
    return {a[5:0] ^ a[11:6], 2'(d), 4'h5};
  endfunction

  always @(posedge clk) begin
    rgb0 <= rom(0, address);
    rgb1 <= rom(1, address);
    rgb2 <= rom(2, address);
    rgb3 <= rom(3, address);
  end

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } out_t;

  out_t expq[$];
  out_t obs;
  int   checks = 0;
  int   failures = 0;

  // Staged control inputs, applied to the DUT at the next driving edge.
  logic        n_rst = 1'b1, n_alive = 1'b1, n_hit = 1'b0;
  logic [10:0] n_xpos = '0, n_ypos = '0;
  logic [1:0]  n_dir = '0;

  // Reference model: latched placement, frame visibility, and life/flash bookkeeping.
  int mx, my, md, age;
  bit mvis, dead, flashing, prev_vs;

  task automatic model_reset();
    mx = 0; my = 0; md = 0; age = 0;
    mvis = 1; dead = 0; flashing = 0; prev_vs = 0;
  endtask

  task automatic chk(string nm, logic [11:0] got, logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic cyc(input logic [10:0] hc, input logic [10:0] vc, input logic hs,
                     input logic vs, input logic hb, input logic vb, input logic [11:0] rin);
    out_t e, got;
    int   dx, dy;
    bit   insp, rise;
    logic [11:0] rv;
    @(negedge clk);
    got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    obs = got;
    if (expq.size() >= 2) begin
      e = expq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL pipe @%0t got hc=%0d vc=%0d sync=%b%b blnk=%b%b rgb=%h expected hc=%0d vc=%0d sync=%b%b blnk=%b%b rgb=%h",
                 $time, got.hc, got.vc, got.hs, got.vs, got.hb, got.vb, got.rgb,
                 e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, e.rgb);
      end
    end
    rst = n_rst; alive = n_alive; hit = n_hit; xpos = n_xpos; ypos = n_ypos; dir = n_dir;
    hcount_in = hc; vcount_in = vc; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rin;
    if (rst) begin
      model_reset();
      foreach (expq[i]) expq[i] = '0;
      e = '0;
    end else begin
      dx   = (int'(hc) + 4096 - mx) % 4096;
      dy   = (int'(vc) + 4096 - my) % 4096;
      insp = (dx < 64) && (dy < 64);
      rv   = rom(md, 12'((dy % 64) * 64 + (dx % 64)));
      e    = {hc, vc, hs, vs, hb, vb,
              (insp && mvis && !hb && !vb && rv != 12'hF0F) ? rv : rin};
      rise    = vs && !prev_vs;
      prev_vs = vs;
      if (!alive) dead = 1;
      else if (dead) begin dead = 0; flashing = 0; end
      else if (hit) begin flashing = 1; age = 0; end
      else if (flashing && rise) begin
        if (age == 15) flashing = 0;
        else age++;
      end
      if (rise) begin
        mx = int'(xpos); my = int'(ypos); md = int'(dir);
        mvis = dead ? 0 : (flashing ? ((age / 4) % 2 == 0) : 1);
      end
    end
    expq.push_back(e);
  endtask

  task automatic px(input int hc, input int vc, input logic [11:0] rin);
    cyc(11'(hc), 11'(vc), 1'b0, 1'b0, 1'b0, 1'b0, rin);
  endtask

  task automatic vpulse();
    cyc(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    cyc(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
  endtask

  // Drive one pixel, then observe its output exactly two edges later.
  task automatic probe(string nm, input int hc, input int vc, input logic hb,
                       input logic [11:0] rin, input logic [11:0] exp);
    cyc(11'(hc), 11'(vc), 1'b0, 1'b0, hb, 1'b0, rin);
    cyc(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    cyc(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    chk(nm, obs.rgb, exp);
  endtask

  function automatic bit flash_vis(int k);
    return (k >= 16) || ((k / 4) % 2 == 0);
  endfunction

  typedef struct {
    int          hc, vc;
    logic        hb;
    logic [11:0] rin, exp;
  } vec_t;

  initial begin
    vec_t tbl [12];
    int   hc, vc;
    tbl[0]  = '{99,  200, 1'b0, 12'h00F, 12'h00F};
    tbl[1]  = '{100, 200, 1'b0, 12'h00F, 12'h0A0};
    tbl[2]  = '{163, 200, 1'b0, 12'h00F, 12'h0A0};
    tbl[3]  = '{164, 200, 1'b0, 12'h00F, 12'h00F};
    tbl[4]  = '{101, 201, 1'b0, 12'h00F, 12'h00F};
    tbl[5]  = '{102, 201, 1'b0, 12'h00F, 12'h0A0};
    tbl[6]  = '{100, 263, 1'b0, 12'h00F, 12'h0A0};
    tbl[7]  = '{100, 264, 1'b0, 12'h00F, 12'h00F};
    tbl[8]  = '{100, 199, 1'b0, 12'h00F, 12'h00F};
    tbl[9]  = '{163, 263, 1'b0, 12'h123, 12'h0A0};
    tbl[10] = '{130, 230, 1'b1, 12'h456, 12'h456};
    tbl[11] = '{0,   0,   1'b0, 12'h789, 12'h789};

    model_reset();
    // Reset with live-looking inputs: every output must stay zero.
    for (int i = 0; i < 3; i++) cyc(11'd55, 11'd66, 1'b1, 1'b0, 1'b1, 1'b1, 12'hABC);
    chk("reset_rgb", obs.rgb, 12'h000);
    chk("reset_hcount", 12'(obs.hc), 12'h000);
    chk("reset_sync", 12'({obs.hs, obs.vs, obs.hb, obs.vb}), 12'h000);
    n_rst = 1'b0;

    // Sprite at (100,200) facing up.
    n_xpos = 11'd100; n_ypos = 11'd200; n_dir = 2'd0;
    vpulse();
    for (int h = 90; h <= 170; h++) px(h, 200, 12'h00F);
    foreach (tbl[i]) probe($sformatf("vec%0d", i), tbl[i].hc, tbl[i].vc, tbl[i].hb,
                           tbl[i].rin, tbl[i].exp);

    // Wrap case: tank straddles the right edge; low columns must not show it.
    n_xpos = 11'd2040;
    vpulse();
    for (int h = 0; h <= 10; h++) probe("wrap_low", h, 200, 1'b0, 12'h00F, 12'h00F);
    probe("wrap_hi", 2045, 210, 1'b0, 12'h00F, 12'h0A0);

    // Direction change mid-frame applies from the next frame only.
    n_xpos = 11'd100;
    vpulse();
    probe("dir_before", 110, 210, 1'b0, 12'h00F, 12'h0A0);
    n_dir = 2'd2;
    probe("dir_midframe", 111, 210, 1'b0, 12'h00F, 12'h0A0);
    vpulse();
    probe("dir_next_frame", 111, 210, 1'b0, 12'h00F, 12'h0C0);

    // Hit flash: 16 frames of 4-frame on/off blocks, then steady.
    for (int f = 0; f < 20; f++) begin
      vpulse();
      if (f == 0) begin
        n_hit = 1'b1; px(0, 0, 12'h000); n_hit = 1'b0;
      end
      probe($sformatf("flash_f%0d", f), 120, 220, 1'b0, 12'h00F,
            flash_vis(f) ? 12'h0C0 : 12'h00F);
    end
    // Second hit at frame 10 restarts the count.
    for (int f = 0; f < 30; f++) begin
      vpulse();
      if (f == 0 || f == 10) begin
        n_hit = 1'b1; px(0, 0, 12'h000); n_hit = 1'b0;
      end
      probe($sformatf("reflash_f%0d", f), 120, 220, 1'b0, 12'h00F,
            flash_vis(f < 10 ? f : f - 10) ? 12'h0C0 : 12'h00F);
    end

    // Dead tank, then reset mid-line: placement and visibility return to defaults.
    n_alive = 1'b0;
    vpulse();
    probe("dead_hidden", 120, 220, 1'b0, 12'h00F, 12'h00F);
    for (int h = 40; h < 44; h++) px(h, 5, 12'h00F);
    n_rst = 1'b1;
    for (int h = 44; h < 47; h++) px(h, 5, 12'h00F);
    chk("midline_rst_rgb", obs.rgb, 12'h000);
    chk("midline_rst_hcount", 12'(obs.hc), 12'h000);
    n_rst = 1'b0;
    n_xpos = 11'd300;
    probe("post_rst_origin", 5, 5, 1'b0, 12'h00F, 12'h0A0);
    probe("post_rst_old_pos", 125, 225, 1'b0, 12'h00F, 12'h00F);
    vpulse();
    probe("post_rst_dead", 5, 5, 1'b0, 12'h00F, 12'h00F);
    n_alive = 1'b1;
    vpulse();
    probe("revived", 305, 205, 1'b0, 12'h00F, 12'h0C0);

    // Randomised traffic against the model with a patterned ROM.
    rom_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        n_xpos = 11'($urandom);
        n_ypos = 11'($urandom);
        n_dir  = 2'($urandom);
      end
      n_alive = ($urandom_range(0, 299) != 0);
      n_hit   = ($urandom_range(0, 149) == 0);
      n_rst   = ($urandom_range(0, 999) == 0);
      hc = (int'(n_xpos) + int'($urandom_range(0, 80)) - 8) & 2047;
      vc = (int'(n_ypos) + int'($urandom_range(0, 80)) - 8) & 2047;
      cyc(11'(hc), 11'(vc), 1'($urandom), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 12'($urandom));
    end
    n_rst = 1'b0; n_hit = 1'b0;
    px(0, 0, 12'h000);
    px(0, 0, 12'h000);
    px(0, 0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
